serial_stream_arbiter: RTL and testbench
========================================

SERIAL_STREAM_ARBITER -- requirements
Module: serial_stream_arbiter

Interface
REQ-001 SHALL have parameter FRAME_W, default 8, bits per serial frame (>=2).
REQ-002 SHALL have parameter CNT_W, default 4, width of the per-frame hit count.
REQ-003 SHALL have port clock  in  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  in  2  request per requester (bit0 = requester 0, bit1 = requester 1), level-held.
REQ-006 SHALL have ports data0, data1  in  FRAME_W  frame word per requester, shifted MSB first.
REQ-007 SHALL have port grant  out  2  one-hot, or zero; marks the requester owning the current frame.
REQ-008 SHALL have port done  out  2  one-hot single-cycle pulse at frame completion.
REQ-009 SHALL have port hits  out  CNT_W  detection count of the finished frame; valid only while done != 0.
REQ-010 SHALL have port busy  out  1  high in every state except IDLE.
REQ-011 SHALL have port det_I  out  1  serial bit driven to the shared sequence detector.
REQ-012 SHALL have port det_rst  out  1  active-high clear to the shared detector.
REQ-013 SHALL have port det_F  in  1  registered (Moore) detector output that reflects bits up to the previous edge.

Function
REQ-014 SHALL implement the states IDLE, CLEAR, SHIFT, DRAIN, DONE.
REQ-015 IDLE with req != 0: SHALL select a winner and latch its data into the shift register. SHALL set grant to the winner and go to CLEAR, all on the same edge.
REQ-016 Arbitration SHALL be round-robin: on a tie, the requester not served last wins. After reset, requester 0 has priority.
REQ-017 CLEAR: SHALL last 1 cycle, with det_rst=1, det_I=0, and the hit counter zeroed.
REQ-018 SHIFT: SHALL last exactly FRAME_W cycles, with det_I = shift-register MSB and a left shift each cycle.
REQ-019 det_F SHALL be sampled in SHIFT cycles 2..FRAME_W and in the single DRAIN cycle. Each sampled 1 SHALL increment the hit counter.
REQ-020 The hit counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-021 DONE: SHALL last 1 cycle, with done[winner]=1, hits=count and grant still asserted. On the next edge it SHALL go to IDLE with grant=0.
REQ-022 Latency: done SHALL rise exactly FRAME_W+2 cycles after grant rises. At least one IDLE cycle SHALL separate frames.
REQ-023 Dropping req mid-frame SHALL NOT abort the frame. The latched data SHALL be used, and done SHALL still pulse.
REQ-024 A change on data0/data1 after latching SHALL have no effect on the current frame.
REQ-025 Outside their own states: det_rst=0, det_I=0, done=0 and hits=0.

Reset
REQ-026 While reset=0, SHALL force state=IDLE, grant=0, done=0, hits=0, busy=0, det_I=0, det_rst=1, counter=0, shift register=0, and round-robin pointer to favour requester 0.
REQ-027 Reset mid-frame SHALL abandon the frame with no done pulse. The first cycle after release SHALL be IDLE with det_rst=0.

Structure
REQ-028 Package serial_arb_pkg SHALL hold the state enum typedef and the default FRAME_W/CNT_W constants.
REQ-029 The winner selection and last-served pointer SHALL be in sub-module rr_arb2. Sequencing, shift and count logic SHALL stay in the top module.
REQ-030 All outputs SHALL be registered. No combinational path SHALL run from det_F to any output.

Verification
REQ-031 The bench SHALL use a behavioural Moore "101" overlapping detector as the det_F source.
REQ-032 req=01, data0=8'b10101010 -> grant=01 for 11 cycles, done=01 one cycle, hits=3.
REQ-033 req=10, data1=8'b10110101 -> hits=3, with the last hit seen only in DRAIN. req=01, data0=8'h00 -> hits=0.
REQ-034 req=11 held from reset -> grant sequence 01,10,01,10, with exactly one IDLE cycle between frames.
REQ-035 CNT_W=1, data0=8'b10101010 -> hits=1 (saturated); req deasserted in SHIFT cycle 3 -> done still pulses.
REQ-036 reset=0 in SHIFT cycle 4 -> all outputs at reset values immediately, det_rst=1, no done; after release a new req gets a full frame.

Source files
------------

// File: rtl/serial_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_arb_pkg
// Purpose  : Shared types and default sizes for the serial stream arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package serial_arb_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int c_frame_w_default = 8;
    localparam int c_cnt_w_default   = 4;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin winner select with a last-served pointer.
//            The winner is combinational; the pointer moves on i_accept.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_winner
);

    // Index of the requester served last; reset value 1 makes requester 0 win the first tie
    logic r_last;

    // Pick the single requester, or on a tie the one not served last
    always_comb begin
        o_winner = 2'b00;
        case (i_req)
            2'b01:   o_winner = 2'b01;
            2'b10:   o_winner = 2'b10;
            2'b11:   o_winner = r_last ? 2'b01 : 2'b10;
            default: o_winner = 2'b00;
        endcase
    end

    // Remember who was granted so the next tie goes the other way
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (i_accept && (o_winner != 2'b00)) begin
            r_last <= o_winner[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serial_stream_arbiter
// Purpose  : Arbitrates two requesters onto a shared serial sequence
//            detector. Each granted frame is cleared, shifted out MSB first,
//            drained one cycle, and its detector hits are reported on done.
// Revision : 1.0 - initial release
// ============================================================================
module serial_stream_arbiter
    import serial_arb_pkg::*;
#(
    parameter int FRAME_W = c_frame_w_default,
    parameter int CNT_W   = c_cnt_w_default
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         req,
    input  logic [FRAME_W-1:0] data0,
    input  logic [FRAME_W-1:0] data1,
    output logic [1:0]         grant,
    output logic [1:0]         done,
    output logic [CNT_W-1:0]   hits,
    output logic               busy,
    output logic               det_I,
    output logic               det_rst,
    input  logic               det_F
);

    localparam int                 c_bc_w    = $clog2(FRAME_W);
    localparam logic [c_bc_w-1:0]  c_bc_last = c_bc_w'(FRAME_W - 1);
    localparam logic [CNT_W-1:0]   c_cnt_max = {CNT_W{1'b1}};

    state_t             r_state;
    logic [FRAME_W-1:0] r_sr;
    logic [c_bc_w-1:0]  r_bitcnt;
    logic [CNT_W-1:0]   r_cnt;

    logic [1:0]         w_winner;
    logic               w_accept;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign w_accept  = (r_state == ST_IDLE) && (req != 2'b00);
    // Saturating increment: the count sticks at its maximum instead of wrapping
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : (r_cnt + CNT_W'(1));

    rr_arb2 u_rr_arb2 (
        .clk      (clock),
        .rst_n    (reset),
        .i_req    (req),
        .i_accept (w_accept),
        .o_winner (w_winner)
    );

    // Frame sequencer: arbitration, detector clear, serial shift, hit counting and completion
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_sr     <= '0;
            r_bitcnt <= '0;
            r_cnt    <= '0;
            grant    <= 2'b00;
            done     <= 2'b00;
            hits     <= '0;
            busy     <= 1'b0;
            det_I    <= 1'b0;
            det_rst  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done    <= 2'b00;
                    hits    <= '0;
                    det_I   <= 1'b0;
                    det_rst <= 1'b0;
                    grant   <= 2'b00;
                    busy    <= 1'b0;
                    if (req != 2'b00) begin
                        r_sr    <= w_winner[1] ? data1 : data0;
                        grant   <= w_winner;
                        r_cnt   <= '0;
                        det_rst <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    det_rst  <= 1'b0;
                    det_I    <= r_sr[FRAME_W-1];
                    r_sr     <= r_sr << 1;
                    r_bitcnt <= '0;
                    r_cnt    <= '0;
                    r_state  <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // The detector output lags one bit, so the first shift cycle carries no result yet
                    if ((r_bitcnt != '0) && det_F) begin
                        r_cnt <= w_cnt_inc;
                    end
                    if (r_bitcnt == c_bc_last) begin
                        det_I   <= 1'b0;
                        r_state <= ST_DRAIN;
                    end else begin
                        det_I    <= r_sr[FRAME_W-1];
                        r_sr     <= r_sr << 1;
                        r_bitcnt <= r_bitcnt + c_bc_w'(1);
                    end
                end
                ST_DRAIN: begin
                    // Last bit's detection shows up here; fold it straight into the reported count
                    r_cnt   <= det_F ? w_cnt_inc : r_cnt;
                    hits    <= det_F ? w_cnt_inc : r_cnt;
                    done    <= grant;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    done    <= 2'b00;
                    hits    <= '0;
                    grant   <= 2'b00;
                    busy    <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    grant   <= 2'b00;
                    done    <= 2'b00;
                    hits    <= '0;
                    busy    <= 1'b0;
                    det_I   <= 1'b0;
                    det_rst <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_stream_arbiter
// Purpose  : Directed bench for serial_stream_arbiter with a behavioural
//            Moore "101" detector per instance and a done-time scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`define CHK(TAG, OBS, EXP) begin checks++; assert ((OBS) === (EXP)) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", TAG, OBS, EXP); end end

module tb_serial_stream_arbiter;

    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req = 2'b00;
    logic [FW-1:0] data0 = '0;
    logic [FW-1:0] data1 = '0;

    logic [1:0] grant_a, done_a, grant_b, done_b;
    logic [3:0] hits_a;
    logic [0:0] hits_b;
    logic       busy_a, det_I_a, det_rst_a, det_F_a;
    logic       busy_b, det_I_b, det_rst_b, det_F_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] g;
        int         h;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    serial_stream_arbiter #(.FRAME_W(FW), .CNT_W(4)) dut (
        .clock(clk), .reset(rst_n), .req(req), .data0(data0), .data1(data1),
        .grant(grant_a), .done(done_a), .hits(hits_a), .busy(busy_a),
        .det_I(det_I_a), .det_rst(det_rst_a), .det_F(det_F_a)
    );

    serial_stream_arbiter #(.FRAME_W(FW), .CNT_W(1)) dut1 (
        .clock(clk), .reset(rst_n), .req(req), .data0(data0), .data1(data1),
        .grant(grant_b), .done(done_b), .hits(hits_b), .busy(busy_b),
        .det_I(det_I_b), .det_rst(det_rst_b), .det_F(det_F_b)
    );

    // Moore overlapping "101" detector: 0=idle, 1="1", 2="10", 3="101"
    function automatic logic [1:0] det_next(input logic [1:0] st, input logic b);
        case (st)
            2'd0:    return b ? 2'd1 : 2'd0;
            2'd1:    return b ? 2'd1 : 2'd2;
            2'd2:    return b ? 2'd3 : 2'd0;
            default: return b ? 2'd1 : 2'd2;
        endcase
    endfunction

    logic [1:0] st_a, st_b;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         st_a <= 2'd0;
        else if (det_rst_a) st_a <= 2'd0;
        else                st_a <= det_next(st_a, det_I_a);
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         st_b <= 2'd0;
        else if (det_rst_b) st_b <= 2'd0;
        else                st_b <= det_next(st_b, det_I_b);
    end
    assign det_F_a = (st_a == 2'd3);
    assign det_F_b = (st_b == 2'd3);

    // Number of "101" matches in a word shifted MSB first from a cleared detector
    function automatic int ref_hits(input logic [FW-1:0] w);
        logic [1:0] st;
        int n;
        st = 2'd0;
        n  = 0;
        for (int k = FW - 1; k >= 0; k--) begin
            st = det_next(st, w[k]);
            if (st == 2'd3) n++;
        end
        return n;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expected frame
    always @(negedge clk) begin
        if (rst_n && ((done_a !== 2'b00) || (done_b !== 2'b00))) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_done observed=%0h expected=0", done_a);
            end else begin
                mon_e = sb.pop_front();
                `CHK("done_a", done_a, mon_e.g)
                `CHK("hits_a", hits_a, 4'(mon_e.h))
                `CHK("done_b", done_b, mon_e.g)
                `CHK("hits_b_sat", hits_b, ((mon_e.h > 0) ? 1'b1 : 1'b0))
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame from the current cycle: waits for grant, checks length, latency and serial bits
    task automatic run_frame(input logic [1:0] eg, input logic [FW-1:0] dw, input int drop_at,
                             input bit scramble, input bit drop_on_done, output int waited);
        exp_t e;
        int i;
        int done_at;
        logic [FW-1:0] got;
        e.g = eg;
        e.h = ref_hits(dw);
        sb.push_back(e);
        waited = 0;
        while ((grant_a === 2'b00) && (waited < 8)) begin
            tick();
            waited++;
        end
        `CHK("grant_start", grant_a, eg)
        `CHK("clear_det_rst", det_rst_a, 1'b1)
        `CHK("clear_det_I", det_I_a, 1'b0)
        `CHK("clear_busy", busy_a, 1'b1)
        i = 0;
        done_at = -1;
        got = '0;
        while ((grant_a === eg) && (i < 20)) begin
            if ((i >= 1) && (i <= FW)) got[FW-i] = det_I_a;
            if (done_a !== 2'b00) begin
                done_at = i;
                if (drop_on_done) req = 2'b00;
            end
            if (scramble && (i == 1)) begin
                data0 = ~data0;
                data1 = ~data1;
            end
            if (i == drop_at) req = 2'b00;
            tick();
            i++;
        end
        `CHK("grant_len", i, FW + 3)
        `CHK("done_latency", done_at, FW + 2)
        `CHK("serial_bits", got, dw)
        `CHK("idle_grant", grant_a, 2'b00)
        `CHK("idle_busy", busy_a, 1'b0)
        `CHK("idle_hits", hits_a, 4'h0)
    endtask

    int w;

    initial begin
        // Reset values
        tick();
        tick();
        `CHK("rst_grant", grant_a, 2'b00)
        `CHK("rst_done", done_a, 2'b00)
        `CHK("rst_hits", hits_a, 4'h0)
        `CHK("rst_busy", busy_a, 1'b0)
        `CHK("rst_det_I", det_I_a, 1'b0)
        `CHK("rst_det_rst", det_rst_a, 1'b1)
        rst_n = 1'b1;
        tick();
        `CHK("release_det_rst", det_rst_a, 1'b0)
        `CHK("release_busy", busy_a, 1'b0)

        // Requester 0 alone, data changed after latching
        data0 = 8'b1010_1010;
        req   = 2'b01;
        run_frame(2'b01, 8'b1010_1010, -1, 1'b1, 1'b1, w);

        // Requester 1 alone, last hit only visible in the drain cycle
        data1 = 8'b1011_0101;
        req   = 2'b10;
        run_frame(2'b10, 8'b1011_0101, -1, 1'b0, 1'b1, w);

        // All-zero frame gives no hits
        data0 = 8'h00;
        req   = 2'b01;
        run_frame(2'b01, 8'h00, -1, 1'b0, 1'b1, w);

        // Request dropped in shift cycle 3 still completes the frame
        data0 = 8'b1010_1010;
        req   = 2'b01;
        run_frame(2'b01, 8'b1010_1010, 3, 1'b0, 1'b0, w);

        // Reset during shift cycle 4 abandons the frame
        data0 = 8'b1010_1010;
        req   = 2'b10;
        data1 = 8'b1010_1010;
        w = 0;
        while ((grant_a === 2'b00) && (w < 8)) begin
            tick();
            w++;
        end
        `CHK("abort_grant", grant_a, 2'b10)
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0;
        req   = 2'b00;
        #1;
        `CHK("abort_grant_rst", grant_a, 2'b00)
        `CHK("abort_busy_rst", busy_a, 1'b0)
        `CHK("abort_det_rst", det_rst_a, 1'b1)
        `CHK("abort_det_I", det_I_a, 1'b0)
        `CHK("abort_done", done_a, 2'b00)
        `CHK("abort_hits", hits_a, 4'h0)
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        `CHK("abort_release_det_rst", det_rst_a, 1'b0)
        `CHK("abort_release_grant", grant_a, 2'b00)

        // Both requesting from reset: alternate with a single idle cycle between frames
        data0 = 8'b1010_1010;
        data1 = 8'hFF;
        req   = 2'b11;
        run_frame(2'b01, 8'b1010_1010, -1, 1'b0, 1'b0, w);
        `CHK("rr_idle_1", w, 1)
        run_frame(2'b10, 8'hFF, -1, 1'b0, 1'b0, w);
        `CHK("rr_idle_2", w, 1)
        run_frame(2'b01, 8'b1010_1010, -1, 1'b0, 1'b0, w);
        `CHK("rr_idle_3", w, 1)
        run_frame(2'b10, 8'hFF, -1, 1'b0, 1'b1, w);
        `CHK("rr_idle_4", w, 1)

        tick();
        tick();
        `CHK("sb_drained", sb.size(), 0)
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`undef CHK
`default_nettype wire
